// File: rtl/rc4_pkg.sv
// ----------------------------------------------------------------------------
// rc4_pkg
// Shared types and constants for the RC4 keystream / decrypt engines.
//   rc4_state_e     : PRGA decryptor FSM states
//   ASCII_*         : bounds of the accepted plaintext alphabet (space, a..z)
//   DEFAULT_MSG_LEN : message length used when the top is not overridden
// ----------------------------------------------------------------------------
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_SI,
        ST_WT_SI,
        ST_RD_SJ,
        ST_WT_SJ,
        ST_WR_SI,
        ST_WR_SJ,
        ST_RD_F,
        ST_WT_F,
        ST_WR_DEC,
        ST_DONE
    } rc4_state_e;

    localparam logic [7:0] ASCII_SPACE     = 8'h20;
    localparam logic [7:0] ASCII_LO        = 8'h61;
    localparam logic [7:0] ASCII_HI        = 8'h7A;
    localparam int         DEFAULT_MSG_LEN = 32;

endpackage

// File: rtl/rc4_ascii_check.sv
// ----------------------------------------------------------------------------
// rc4_ascii_check
// Combinational plaintext filter: a byte is accepted when it is a space or a
// lowercase letter. Also used by the key-search controller.
//   i_byte  : candidate plaintext byte
//   o_valid : 1 when i_byte is in {space, a..z}
// ----------------------------------------------------------------------------
module rc4_ascii_check
    import rc4_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_valid
);

    assign o_valid = (i_byte == ASCII_SPACE) ||
                     ((i_byte >= ASCII_LO) && (i_byte <= ASCII_HI));

endmodule

// File: rtl/rc4_prga_decryptor.sv
// ----------------------------------------------------------------------------
// rc4_prga_decryptor
// RC4 keystream generator (PRGA) and decryptor. Walks an already key-scheduled
// S-memory, swapping S[i]/S[j] per byte, XORs the keystream byte with the
// encrypted ROM and writes plaintext into the decrypted RAM. Nine cycles per
// byte; all memory outputs are registered.
//   clk, rst_n            : clock, async active-low reset
//   start                 : level enable, held high for the run
//   s_address/s_data/
//   s_wren/s_read_data    : S-memory port (1-cycle read latency)
//   rom_address/rom_q     : encrypted ROM (1-cycle read latency)
//   dec_address/dec_data/
//   dec_wren              : decrypted-message RAM write port
//   done/success          : run finished; success=0 means plaintext check abort
// ----------------------------------------------------------------------------
module rc4_prga_decryptor
    import rc4_pkg::*;
#(
    parameter int MSG_LEN     = DEFAULT_MSG_LEN,
    parameter int CHECK_ASCII = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] s_read_data,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    output logic       s_wren,
    output logic [7:0] rom_address,
    input  logic [7:0] rom_q,
    output logic [7:0] dec_address,
    output logic [7:0] dec_data,
    output logic       dec_wren,
    output logic       done,
    output logic       success
);

    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

    rc4_state_e r_state;
    logic [7:0] r_i, r_j, r_k, r_si, r_sj, r_db;

    logic [7:0] w_j_next;
    logic [7:0] w_f_addr;
    logic [7:0] w_db;
    logic       w_db_valid;

    assign w_j_next = r_j + s_read_data;
    // After the swap S[i]+S[j] is still si+sj, so no re-read is needed.
    assign w_f_addr = r_si + r_sj;
    assign w_db     = s_read_data ^ rom_q;

    rc4_ascii_check u_ascii (
        .i_byte  (r_db),
        .o_valid (w_db_valid)
    );

    // Outputs are registered: each transition loads the values belonging to
    // the state being entered, so they are stable for that whole state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_db        <= '0;
            s_address   <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            rom_address <= '0;
            dec_address <= '0;
            dec_data    <= '0;
            dec_wren    <= 1'b0;
            done        <= 1'b0;
            success     <= 1'b0;
        end else begin
            s_address   <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            dec_address <= '0;
            dec_data    <= '0;
            dec_wren    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_i         <= 8'd1;
                        r_j         <= '0;
                        r_k         <= '0;
                        s_address   <= 8'd1;
                        rom_address <= '0;
                        r_state     <= ST_RD_SI;
                    end
                end
                ST_RD_SI: r_state <= ST_WT_SI;
                ST_WT_SI: begin
                    r_si      <= s_read_data;
                    r_j       <= w_j_next;
                    s_address <= w_j_next;
                    r_state   <= ST_RD_SJ;
                end
                ST_RD_SJ: r_state <= ST_WT_SJ;
                ST_WT_SJ: begin
                    r_sj      <= s_read_data;
                    s_address <= r_i;
                    s_data    <= s_read_data;
                    s_wren    <= 1'b1;
                    r_state   <= ST_WR_SI;
                end
                ST_WR_SI: begin
                    // When i==j this rewrites the same cell with the same byte.
                    s_address <= r_j;
                    s_data    <= r_si;
                    s_wren    <= 1'b1;
                    r_state   <= ST_WR_SJ;
                end
                ST_WR_SJ: begin
                    s_address <= w_f_addr;
                    r_state   <= ST_RD_F;
                end
                ST_RD_F: r_state <= ST_WT_F;
                ST_WT_F: begin
                    r_db        <= w_db;
                    dec_address <= r_k;
                    dec_data    <= w_db;
                    dec_wren    <= 1'b1;
                    r_state     <= ST_WR_DEC;
                end
                ST_WR_DEC: begin
                    if ((CHECK_ASCII != 0) && !w_db_valid) begin
                        done    <= 1'b1;
                        success <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_k == LAST_K) begin
                        done    <= 1'b1;
                        success <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_k         <= r_k + 8'd1;
                        r_i         <= r_i + 8'd1;
                        s_address   <= r_i + 8'd1;
                        rom_address <= r_k + 8'd1;
                        r_state     <= ST_RD_SI;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        done        <= 1'b0;
                        success     <= 1'b0;
                        rom_address <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    rom_address <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
